// File: rtl/gpll_recfg_pkg.sv
// Shared types and preset ROM for the GPLL APB reconfiguration controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package gpll_recfg_pkg;

   typedef struct packed {
      logic [4:0]  addr;
      logic [15:0] data;
   } entry_t;

   typedef enum logic [2:0] {
      IDLE, HOLD, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, RELEASE, WAIT_LOCK
   } state_t;

   // Entries are written in index order; addresses within a preset are unique.
   localparam entry_t GPLL_PRESETS [2][16] = '{
      '{ '{5'h00, 16'h1A01}, '{5'h01, 16'h0033}, '{5'h02, 16'h4C12}, '{5'h03, 16'h00F0},
         '{5'h04, 16'h7721}, '{5'h05, 16'h0101}, '{5'h06, 16'h3E0C}, '{5'h07, 16'h8001},
         '{5'h08, 16'h0000}, '{5'h09, 16'h0000}, '{5'h0A, 16'h0000}, '{5'h0B, 16'h0000},
         '{5'h0C, 16'h0000}, '{5'h0D, 16'h0000}, '{5'h0E, 16'h0000}, '{5'h0F, 16'h0000} },
      '{ '{5'h00, 16'h2B05}, '{5'h01, 16'h0047}, '{5'h02, 16'h5D18}, '{5'h03, 16'h00E3},
         '{5'h04, 16'h6612}, '{5'h05, 16'h0202}, '{5'h06, 16'h1F0A}, '{5'h07, 16'h8003},
         '{5'h08, 16'h0000}, '{5'h09, 16'h0000}, '{5'h0A, 16'h0000}, '{5'h0B, 16'h0000},
         '{5'h0C, 16'h0000}, '{5'h0D, 16'h0000}, '{5'h0E, 16'h0000}, '{5'h0F, 16'h0000} }
   };

endpackage

// File: rtl/gpll_apb_reconfig_sync2.sv
// Two-flop synchronizer bringing the PLL lock indication into the controller clock domain.
// Latency: 2 cycles.
// Backpressure: none.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/gpll_apb_reconfig.sv
// APB initiator reprogramming the GPLL config port; GPLL_RECFG_VERIFY_EN adds per-entry readback.
// Latency: RST_HOLD + 2 cycles per write (4 with readback) + 1 release + sync + 1 to done.
// Backpressure: access phases stall while apb_ready is low; start is ignored until idle.
module gpll_apb_reconfig #(
   parameter int NUM_ENTRIES  = 8,
   parameter int RST_HOLD     = 16,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic        apb_clk,
   input  logic        apb_rst_n,
   input  logic        start,
   input  logic        sel,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [4:0]  apb_addr,
   output logic        apb_sel,
   output logic        apb_en,
   output logic        apb_write,
   output logic [15:0] apb_wdata,
   input  logic [15:0] apb_rdata,
   input  logic        apb_ready,
   output logic        pll_rst,
   input  logic        pll_lock
);
   import gpll_recfg_pkg::*;

   localparam int CNT_MAX = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
   localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0] TMO_END  = CNT_W'(LOCK_TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             sel_q;
   logic             lock_s;
   entry_t           cur;
   entry_t           nxt;

   sync2 u_lock_sync (.clk(apb_clk), .rst_n(apb_rst_n), .d(pll_lock), .q(lock_s));

   assign cur = GPLL_PRESETS[sel_q][4'(idx)];
   assign nxt = GPLL_PRESETS[sel_q][4'(idx + 1'b1)];

`ifndef GPLL_RECFG_VERIFY_EN
   logic unused_rdata;
   assign unused_rdata = ^apb_rdata;
`endif

   always_ff @(posedge apb_clk or negedge apb_rst_n) begin
      if (!apb_rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         sel_q     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         apb_addr  <= '0;
         apb_sel   <= 1'b0;
         apb_en    <= 1'b0;
         apb_write <= 1'b0;
         apb_wdata <= '0;
         pll_rst   <= 1'b0;
      end else begin
         done <= 1'b0;
         // Free-running saturating count; cleared on entry to each timed state.
         if (cnt != '1) cnt <= cnt + 1'b1;
         case (state)
            IDLE: if (start) begin
               sel_q   <= sel;
               err     <= 1'b0;
               cnt     <= '0;
               idx     <= '0;
               busy    <= 1'b1;
               pll_rst <= 1'b1;
               state   <= HOLD;
            end
            HOLD: if (cnt == HOLD_END) begin
               apb_sel   <= 1'b1;
               apb_write <= 1'b1;
               apb_addr  <= cur.addr;
               apb_wdata <= cur.data;
               state     <= WR_SETUP;
            end
            WR_SETUP: begin
               apb_en <= 1'b1;
               state  <= WR_ACCESS;
            end
            WR_ACCESS: if (apb_ready) begin
               apb_en <= 1'b0;
`ifdef GPLL_RECFG_VERIFY_EN
               apb_write <= 1'b0;
               state     <= RD_SETUP;
            end
            RD_SETUP: begin
               apb_en <= 1'b1;
               state  <= RD_ACCESS;
            end
            RD_ACCESS: if (apb_ready) begin
               apb_en <= 1'b0;
               // A failed readback aborts: PLL is released and the lock wait is skipped.
               if (apb_rdata != apb_wdata) begin
                  err       <= 1'b1;
                  busy      <= 1'b0;
                  pll_rst   <= 1'b0;
                  apb_sel   <= 1'b0;
                  apb_addr  <= '0;
                  apb_wdata <= '0;
                  state     <= IDLE;
               end else
`endif
               if (idx == LAST_IDX) begin
                  apb_sel   <= 1'b0;
                  apb_write <= 1'b0;
                  apb_addr  <= '0;
                  apb_wdata <= '0;
                  pll_rst   <= 1'b0;
                  cnt       <= '0;
                  state     <= RELEASE;
               end else begin
                  idx       <= idx + 1'b1;
                  apb_write <= 1'b1;
                  apb_addr  <= nxt.addr;
                  apb_wdata <= nxt.data;
                  state     <= WR_SETUP;
               end
            end
            RELEASE: state <= WAIT_LOCK;
            WAIT_LOCK: if (lock_s) begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end else if (cnt == TMO_END) begin
               err   <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gpll_apb_reconfig.sv
// Bench for gpll_apb_reconfig: timeline model of expected outputs per cycle, plus literal pins.
module tb_gpll_apb_reconfig;
   localparam int H = 16, N = 8, T = 100;
`ifdef GPLL_RECFG_VERIFY_EN
   localparam int ENTRY_CYC = 4, PW = 48, DONE_T = 56, TO_T = 148;
`else
   localparam int ENTRY_CYC = 2, PW = 32, DONE_T = 40, TO_T = 132;
`endif

   localparam logic [20:0] ROM [2][8] = '{
      '{ {5'h00, 16'h1A01}, {5'h01, 16'h0033}, {5'h02, 16'h4C12}, {5'h03, 16'h00F0},
         {5'h04, 16'h7721}, {5'h05, 16'h0101}, {5'h06, 16'h3E0C}, {5'h07, 16'h8001} },
      '{ {5'h00, 16'h2B05}, {5'h01, 16'h0047}, {5'h02, 16'h5D18}, {5'h03, 16'h00E3},
         {5'h04, 16'h6612}, {5'h05, 16'h0202}, {5'h06, 16'h1F0A}, {5'h07, 16'h8003} } };

   typedef struct packed {
      logic busy, done, err, pll_rst, psel, pen, pwr;
      logic [4:0]  addr;
      logic [15:0] wdata;
   } obs_t;

   logic apb_clk, apb_rst_n, start, sel, busy, done, err;
   logic [4:0] apb_addr;
   logic apb_sel, apb_en, apb_write, apb_ready, pll_rst, pll_lock, flip;
   logic [15:0] apb_wdata, apb_rdata;
   logic [15:0] mem [32];
   obs_t dut_o;

   int vectors = 0, miscompares = 0;
   int cur_t, rst_cnt, done_cnt, err_t, done_t;
   bit active;
   int m_sel, m_stall_k, m_stall_n, m_lock_d, m_bad_k;
   logic [20:0] wq [$];

   gpll_apb_reconfig #(.NUM_ENTRIES(N), .RST_HOLD(H), .LOCK_TIMEOUT(T)) dut (
      .apb_clk(apb_clk), .apb_rst_n(apb_rst_n), .start(start), .sel(sel),
      .busy(busy), .done(done), .err(err), .apb_addr(apb_addr), .apb_sel(apb_sel),
      .apb_en(apb_en), .apb_write(apb_write), .apb_wdata(apb_wdata),
      .apb_rdata(apb_rdata), .apb_ready(apb_ready), .pll_rst(pll_rst), .pll_lock(pll_lock));

   assign dut_o = {busy, done, err, pll_rst, apb_sel, apb_en, apb_write, apb_addr, apb_wdata};
   assign apb_rdata = mem[apb_addr] ^ {15'b0, flip};

   always #5 apb_clk = ~apb_clk;

   // Simple APB slave memory so readback returns what was written.
   always @(posedge apb_clk)
      if (apb_sel && apb_en && apb_write && apb_ready) mem[apb_addr] <= apb_wdata;

   // Cycle at which entry k's write setup phase begins (k == N gives the release cycle).
   function automatic int entry_t0(input int k);
      int s = H;
      for (int j = 0; j < k; j++) s += ENTRY_CYC + ((j == m_stall_k) ? m_stall_n : 0);
      return s;
   endfunction

   function automatic int seq_end();
      if (m_bad_k >= 0) return entry_t0(m_bad_k) + 4;
      if (m_lock_d >= 0) return entry_t0(N) + m_lock_d + 3;
      return entry_t0(N) + T;
   endfunction

   // Expected outputs t cycles after start was accepted; m masks bits that carry no meaning.
   function automatic void model(input int t, output obs_t e, output obs_t m);
      int s = H;
      int w;
      logic [20:0] ent;
      e = '0; m = '1; e.busy = 1'b1;
      if (t < H) begin e.pll_rst = 1'b1; return; end
      for (int k = 0; k < N; k++) begin
         ent = ROM[m_sel][k];
         w = (k == m_stall_k) ? m_stall_n : 0;
         if (t <= s + 1 + w) begin
            e.pll_rst = 1'b1; e.psel = 1'b1; e.pwr = 1'b1; e.pen = (t > s);
            e.addr = ent[20:16]; e.wdata = ent[15:0];
            return;
         end
         s += 2 + w;
`ifdef GPLL_RECFG_VERIFY_EN
         if (t <= s + 1) begin
            e.pll_rst = 1'b1; e.psel = 1'b1; e.pen = (t > s);
            e.addr = ent[20:16]; m.wdata = '0;
            return;
         end
         s += 2;
         if (k == m_bad_k) begin e.busy = 1'b0; e.err = 1'b1; return; end
`endif
      end
      if (t == s) return;
      if (m_lock_d >= 0) begin
         if (t < s + m_lock_d + 3) return;
         e.busy = 1'b0;
         e.done = (t == s + m_lock_d + 3);
      end else begin
         if (t < s + T) return;
         e.busy = 1'b0;
         e.err  = 1'b1;
      end
   endfunction

   always @(negedge apb_clk) begin
      obs_t e, m;
      if (active) begin
         model(cur_t, e, m);
         if (!e.psel) begin m.addr = '0; m.wdata = '0; end
         vectors++;
         if ((dut_o & m) !== (e & m)) begin
            miscompares++;
            $display("FAIL cycle t=%0d: got %h want %h (mask %h)", cur_t, dut_o, e, m);
         end
         if (pll_rst) rst_cnt++;
         if (done) begin done_cnt++; if (done_t < 0) done_t = cur_t; end
         if (err && err_t < 0) err_t = cur_t;
         if (apb_sel && apb_en && apb_write && apb_ready) wq.push_back({apb_addr, apb_wdata});
      end
   end

   task automatic check(input string name, input int got, input int want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic run_seq(input int sel_v, input int stall_k, input int stall_n,
                          input int lock_d, input int bad_k, input int poke_t);
      int last;
      m_sel = sel_v; m_stall_k = stall_k; m_stall_n = stall_n; m_lock_d = lock_d; m_bad_k = bad_k;
      rst_cnt = 0; done_cnt = 0; err_t = -1; done_t = -1; wq.delete();
      last = seq_end();
      @(posedge apb_clk); #1;
      start = 1'b1; sel = sel_v[0]; pll_lock = 1'b0; apb_ready = 1'b1; flip = 1'b0;
      for (int t = 0; t <= last + 4; t++) begin
         @(posedge apb_clk); #1;
         cur_t = t; active = 1'b1;
         start = (t == poke_t);
         sel = (t == poke_t) ? ~sel_v[0] : sel_v[0];
         apb_ready = !(stall_k >= 0 && t > entry_t0(stall_k) && t <= entry_t0(stall_k) + stall_n);
         pll_lock = (lock_d >= 0 && t >= entry_t0(N) + lock_d);
         flip = (bad_k >= 0 && t == entry_t0(bad_k) + 3);
      end
      @(negedge apb_clk); #1;
      active = 1'b0;
   endtask

   task automatic check_writes(input string name, input int n);
      check({name, "_count"}, wq.size(), n);
      for (int k = 0; k < wq.size() && k < n; k++) check({name, "_entry"}, int'(wq[k]), int'(ROM[m_sel][k]));
   endtask

   initial begin
      apb_clk = 1'b0; apb_rst_n = 1'b0; start = 1'b0; sel = 1'b0;
      apb_ready = 1'b1; pll_lock = 1'b0; flip = 1'b0; active = 1'b0;
      #12;
      check("reset_outputs", int'(dut_o), 0);
      @(posedge apb_clk); #1 apb_rst_n = 1'b1;

      // Nominal: preset 0, lock 5 cycles after release.
      run_seq(0, -1, 0, 5, -1, -1);
      check("t1_rst_high", rst_cnt, PW);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_done_t", done_t, DONE_T);
      check("t1_err", err_t, -1);
      check_writes("t1_writes", N);
      check("t1_first_wr", int'(wq[0]), int'({5'h00, 16'h1A01}));
      check("t1_last_wr", int'(wq[7]), int'({5'h07, 16'h8001}));

      // Three wait states on entry 2.
      run_seq(0, 2, 3, 5, -1, -1);
      check("t2_rst_high", rst_cnt, PW + 3);
      check("t2_done_cnt", done_cnt, 1);
      check_writes("t2_writes", N);

      // Lock never arrives: timeout.
      run_seq(1, -1, 0, -1, -1, -1);
      check("t3_err_t", err_t, TO_T);
      check("t3_done_cnt", done_cnt, 0);

      // Start with toggled sel during a write access is ignored; err cleared by this start.
      run_seq(1, -1, 0, 5, -1, entry_t0(1) + 1);
      check("t4_done_cnt", done_cnt, 1);
      check("t4_err", err_t, -1);
      check("t4_first_wr", int'(wq[0]), int'({5'h00, 16'h2B05}));
      check_writes("t4_writes", N);

      // Asynchronous reset during entry 4.
      m_sel = 0; m_stall_k = -1; m_stall_n = 0; m_lock_d = 5; m_bad_k = -1;
      @(posedge apb_clk); #1;
      start = 1'b1; sel = 1'b0; pll_lock = 1'b0; apb_ready = 1'b1;
      for (int t = 0; t <= entry_t0(4) + 1; t++) begin
         @(posedge apb_clk); #1;
         start = 1'b0; cur_t = t; active = 1'b1;
      end
      #2 active = 1'b0;
      apb_rst_n = 1'b0;
      #1 check("t5_async_reset", int'(dut_o), 0);
      @(posedge apb_clk); #1 apb_rst_n = 1'b1;
      repeat (6) begin
         @(negedge apb_clk);
         check("t5_idle_after_reset", int'({apb_sel, apb_en, busy, pll_rst}), 0);
      end

`ifdef GPLL_RECFG_VERIFY_EN
      // Corrupted readback of entry 3 aborts the sequence.
      run_seq(0, -1, 0, -1, 3, -1);
      check("t6_err_t", err_t, 32);
      check("t6_done_cnt", done_cnt, 0);
      check("t6_rst_high", rst_cnt, 32);
      check_writes("t6_writes", 4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
